// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared definitions for the MIPS PC sequencer.
//                Sequencer state encoding and the default reset/exception
//                vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Sequencer state encoding (2-bit)
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } seq_state_e;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h0000_0080;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/next_pc_calc.sv
`default_nettype none
// ============================================================================
//  Module      : next_pc_calc
//  Description : Combinational next-PC priority mux for the RUN state.
//                Picks exactly one source (exception, misaligned JR, stall,
//                halt, JR, jump, branch, sequential) and reports the side
//                effects the sequencer must apply.
//  Ports       : pc_i/pc_plus4_i      current PC and PC+4
//                *_i control inputs   decoded control requests
//                pc_next_o            PC to load on the next edge
//                epc_load_o           save current PC into EPC
//                misaligned_o         JR target not word aligned
//                retire_o             instruction retires this cycle
//                enter_halt_o         move to HALT
//  Revision    : 1.0 - initial release
// ============================================================================
module next_pc_calc #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic [31:0] pc_i,
    input  logic [31:0] pc_plus4_i,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_offset_i,
    input  logic        jump_i,
    input  logic [25:0] jump_index_i,
    input  logic        jr_i,
    input  logic [31:0] jr_target_i,
    input  logic        exception_i,
    input  logic        halt_i,
    output logic [31:0] pc_next_o,
    output logic        epc_load_o,
    output logic        misaligned_o,
    output logic        retire_o,
    output logic        enter_halt_o
);

    logic w_jr_misaligned;
    assign w_jr_misaligned = jr_i && (jr_target_i[1:0] != 2'b00);

    always_comb begin
        pc_next_o    = pc_plus4_i;
        epc_load_o   = 1'b0;
        misaligned_o = 1'b0;
        retire_o     = 1'b1;
        enter_halt_o = 1'b0;

        if (exception_i) begin
            pc_next_o  = EXC_VECTOR;
            epc_load_o = 1'b1;
            retire_o   = 1'b0;
        end else if (w_jr_misaligned) begin
            pc_next_o    = EXC_VECTOR;
            epc_load_o   = 1'b1;
            misaligned_o = 1'b1;
            retire_o     = 1'b0;
        end else if (stall_i) begin
            pc_next_o = pc_i;
            retire_o  = 1'b0;
        end else if (halt_i) begin
            // The halt instruction itself retires; fetch resumes after it.
            pc_next_o    = pc_plus4_i;
            enter_halt_o = 1'b1;
        end else if (jr_i) begin
            pc_next_o = jr_target_i;
        end else if (jump_i) begin
            pc_next_o = {pc_plus4_i[31:28], jump_index_i, 2'b00};
        end else if (branch_taken_i) begin
            pc_next_o = pc_plus4_i + {branch_offset_i[29:0], 2'b00};
        end
    end

endmodule : next_pc_calc
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Owns the MIPS program counter. BOOT/RUN/HALT state machine,
//                EPC capture, retired-instruction counter and misaligned-JR
//                pulse. Next-PC selection lives in next_pc_calc.
//  Ports       : clk, rst_n           clock / async active-low reset
//                stall .. resume      control requests from decode
//                pc, pc_plus4         fetch address and its successor
//                fetch_valid          pc is a valid fetch (RUN state)
//                epc                  PC saved on last exception
//                instret              retired-instruction counter
//                misaligned           one-cycle pulse on unaligned JR
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] EXC_VECTOR   = DEFAULT_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        exception,
    input  logic        halt,
    input  logic        resume,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic [31:0] epc,
    output logic [31:0] instret,
    output logic        misaligned
);

    seq_state_e  state_q;
    logic [31:0] pc_q;
    logic [31:0] epc_q;
    logic [31:0] instret_q;
    logic        misaligned_q;

    logic [31:0] pc_d;
    logic        w_epc_load;
    logic        w_misaligned;
    logic        w_retire;
    logic        w_enter_halt;

    assign pc_plus4 = pc_q + 32'd4;

    next_pc_calc #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next_pc_calc (
        .pc_i            (pc_q),
        .pc_plus4_i      (pc_plus4),
        .stall_i         (stall),
        .branch_taken_i  (branch_taken),
        .branch_offset_i (branch_offset),
        .jump_i          (jump),
        .jump_index_i    (jump_index),
        .jr_i            (jr),
        .jr_target_i     (jr_target),
        .exception_i     (exception),
        .halt_i          (halt),
        .pc_next_o       (pc_d),
        .epc_load_o      (w_epc_load),
        .misaligned_o    (w_misaligned),
        .retire_o        (w_retire),
        .enter_halt_o    (w_enter_halt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_VECTOR;
            epc_q        <= 32'd0;
            instret_q    <= 32'd0;
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= 1'b0;
            case (state_q)
                ST_BOOT: begin
                    // One settling cycle; control inputs are ignored here.
                    state_q <= ST_RUN;
                end
                ST_RUN: begin
                    pc_q         <= pc_d;
                    misaligned_q <= w_misaligned;
                    if (w_epc_load)   epc_q     <= pc_q;
                    if (w_retire)     instret_q <= instret_q + 32'd1;
                    if (w_enter_halt) state_q   <= ST_HALT;
                end
                ST_HALT: begin
                    // Exception takes priority over resume.
                    if (exception) begin
                        pc_q    <= EXC_VECTOR;
                        epc_q   <= pc_q;
                        state_q <= ST_RUN;
                    end else if (resume) begin
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    state_q <= ST_BOOT;
                end
            endcase
        end
    end

    assign pc          = pc_q;
    assign epc         = epc_q;
    assign instret     = instret_q;
    assign misaligned  = misaligned_q;
    assign fetch_valid = (state_q == ST_RUN);

endmodule : pc_sequencer
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Directed self-checking bench for pc_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        jr;
    logic [31:0] jr_target;
    logic        exception;
    logic        halt;
    logic        resume;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic [31:0] epc;
    logic [31:0] instret;
    logic        misaligned;

    int n_cmp;
    int n_err;

    pc_sequencer u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_index    (jump_index),
        .jr            (jr),
        .jr_target     (jr_target),
        .exception     (exception),
        .halt          (halt),
        .resume        (resume),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .fetch_valid   (fetch_valid),
        .epc           (epc),
        .instret       (instret),
        .misaligned    (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_offset = 32'd0;
        jump          = 1'b0;
        jump_index    = 26'd0;
        jr            = 1'b0;
        jr_target     = 32'd0;
        exception     = 1'b0;
        halt          = 1'b0;
        resume        = 1'b0;
    endtask

    task automatic check_run(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_ir);
        check({tag, "_pc"}, pc, exp_pc);
        check({tag, "_instret"}, instret, exp_ir);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        clear_inputs();
        #12;
        check("rst_pc", pc, 32'h0);
        check("rst_fv", {31'd0, fetch_valid}, 32'd0);
        check("rst_epc", epc, 32'h0);
        check("rst_instret", instret, 32'h0);
        check("rst_mis", {31'd0, misaligned}, 32'd0);
        check("rst_pc4", pc_plus4, 32'h4);

        // Release reset; exception during BOOT must be ignored.
        @(posedge clk); #1;
        rst_n     = 1'b1;
        exception = 1'b1;
        check("boot_fv", {31'd0, fetch_valid}, 32'd0);
        tick();
        check("boot_pc", pc, 32'h0);
        check("boot_epc", epc, 32'h0);
        check("run_fv", {31'd0, fetch_valid}, 32'd1);
        exception = 1'b0;

        // Sequential fetch.
        tick(); check_run("seq1", 32'h4, 32'd1);
        tick(); check_run("seq2", 32'h8, 32'd2);
        tick(); check_run("seq3", 32'hC, 32'd3);
        tick(); check_run("seq4", 32'h10, 32'd4);

        // Backward branch: 0x14 + (-2 << 2) = 0x0C.
        branch_taken  = 1'b1;
        branch_offset = 32'hFFFF_FFFE;
        tick(); check_run("branch", 32'hC, 32'd5);
        clear_inputs();

        // Jump: {0x0, 26'h40, 2'b00} = 0x100.
        jump       = 1'b1;
        jump_index = 26'h40;
        tick(); check_run("jump", 32'h100, 32'd6);
        clear_inputs();

        // Aligned JR, with jump also asserted (JR wins).
        jr         = 1'b1;
        jr_target  = 32'h2000;
        jump       = 1'b1;
        jump_index = 26'h3;
        tick(); check_run("jr", 32'h2000, 32'd7);
        clear_inputs();

        // Misaligned JR, with stall also asserted (misaligned wins).
        jr        = 1'b1;
        jr_target = 32'h2002;
        stall     = 1'b1;
        tick();
        check_run("jrmis", 32'h80, 32'd7);
        check("jrmis_epc", epc, 32'h2000);
        check("jrmis_pulse", {31'd0, misaligned}, 32'd1);
        clear_inputs();
        tick();
        check("jrmis_pulse_end", {31'd0, misaligned}, 32'd0);
        check_run("post_exc", 32'h84, 32'd8);

        // Jump to 0x24.
        jump       = 1'b1;
        jump_index = 26'h9;
        tick(); check_run("jmp24", 32'h24, 32'd9);

        // Stall for three cycles with jump to 0x30 pending.
        jump_index = 26'hC;
        stall      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); check_run("stall", 32'h24, 32'd9);
        end
        stall = 1'b0;
        tick(); check_run("stall_rel", 32'h30, 32'd10);
        clear_inputs();

        // Halt at 0x30 also branches? No: halt outranks branch.
        halt          = 1'b1;
        branch_taken  = 1'b1;
        branch_offset = 32'h10;
        tick();
        check_run("halt", 32'h34, 32'd11);
        check("halt_fv", {31'd0, fetch_valid}, 32'd0);
        clear_inputs();
        jump       = 1'b1;
        jump_index = 26'h55;
        tick();
        check_run("halt_hold", 32'h34, 32'd11);
        check("halt_hold_fv", {31'd0, fetch_valid}, 32'd0);
        clear_inputs();

        // Resume and exception together: exception wins.
        resume    = 1'b1;
        exception = 1'b1;
        tick();
        check_run("halt_exc", 32'h80, 32'd11);
        check("halt_exc_epc", epc, 32'h34);
        check("halt_exc_fv", {31'd0, fetch_valid}, 32'd1);
        clear_inputs();

        // Plain exception in RUN with stall: exception wins, no retire.
        exception = 1'b1;
        stall     = 1'b1;
        tick();
        check_run("run_exc", 32'h80, 32'd11);
        check("run_exc_epc", epc, 32'h80);
        clear_inputs();

        // Halt again, then plain resume keeps pc.
        halt = 1'b1;
        tick(); check_run("halt2", 32'h84, 32'd12);
        clear_inputs();
        resume = 1'b1;
        tick();
        check_run("resume", 32'h84, 32'd12);
        check("resume_fv", {31'd0, fetch_valid}, 32'd1);
        clear_inputs();
        halt = 1'b1;
        tick(); check_run("halt3", 32'h88, 32'd13);
        clear_inputs();

        // Asynchronous reset mid-cycle while halted.
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_pc", pc, 32'h0);
        check("areset_epc", epc, 32'h0);
        check("areset_instret", instret, 32'h0);
        check("areset_fv", {31'd0, fetch_valid}, 32'd0);
        tick();
        check("areset_hold_pc", pc, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_pc_sequencer
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Controller that owns the MIPS program counter register and decides its next value every cycle.
- Next-PC sources: sequential, branch, jump, jump-register, exception vector; also handles stall, halt/resume and boot sequencing.
- Sits between the decode/control unit and instruction memory; replaces direct drive of the PC input. Single-cycle datapath, no branch delay slot.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_0080, PC value loaded on exception.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold PC this cycle.
- branch_taken  in  1  conditional branch resolved taken.
- branch_offset  in  32  sign-extended 16-bit immediate, in words.
- jump  in  1  J/JAL.
- jump_index  in  26  instruction index field.
- jr  in  1  JR/JALR.
- jr_target  in  32  register-sourced target.
- exception  in  1  external exception/interrupt request.
- halt  in  1  halt instruction decoded.
- resume  in  1  leave HALT.
- pc  out  32  current fetch address.
- pc_plus4  out  32  pc + 4 (combinational, mod 2^32).
- fetch_valid  out  1  pc is a valid fetch this cycle.
- epc  out  32  address saved on last exception.
- instret  out  32  retired-instruction counter.
- misaligned  out  1  one-cycle pulse: JR to unaligned target.

Behaviour:
- Reset (async, rst_n=0): state=BOOT, pc=RESET_VECTOR, epc=0, instret=0, misaligned=0, fetch_valid=0.
- FSM states: BOOT, RUN, HALT (2-bit encoding).
- BOOT: lasts exactly one cycle after rst_n deasserts; pc unchanged; all control inputs ignored; goes to RUN.
- RUN: fetch_valid=1. Next-PC priority, highest first:
  - 1. exception: pc<=EXC_VECTOR, epc<=pc.
  - 2. jr with jr_target[1:0]!=0: pc<=EXC_VECTOR, epc<=pc, misaligned=1 next cycle.
  - 3. stall: pc holds.
  - 4. halt: pc<=pc_plus4, state<=HALT.
  - 5. jr: pc<=jr_target.
  - 6. jump: pc<={pc_plus4[31:28], jump_index, 2'b00}.
  - 7. branch_taken: pc<=pc_plus4 + (branch_offset<<2), 32-bit wrap.
  - 8. otherwise pc<=pc_plus4.
- instret: +1 on every RUN cycle where no exception, no misaligned JR and no stall. Includes the halt instruction. Wraps 2^32-1 to 0.
- HALT: fetch_valid=0; pc holds; instret holds.
  - exception: pc<=EXC_VECTOR, epc<=pc, state<=RUN.
  - else resume: state<=RUN, pc unchanged.
  - Exception wins over resume.
- Simultaneous requests: only the highest priority acts. Lower-priority requests in the same cycle are dropped, not queued.
- pc update latency: 1 cycle from inputs sampled at the rising edge.
- misaligned: registered pulse, high exactly one cycle.
- rst_n asserted mid-operation: immediate return to reset values regardless of state; no partial update.

Decomposition:
- Shared package mips_pkg:
  - state encoding constants ST_BOOT=0, ST_RUN=1, ST_HALT=2.
  - default vector constants.
- Natural sub-module: next_pc_calc (combinational target/priority mux).
- Registers, FSM and counters stay in pc_sequencer.

Test Plan:
- Reset then release: pc=0, fetch_valid=0 for one cycle; then RUN, pc 0→4→8→0xC, instret 0→1→2→3.
- At pc=0x10, branch_taken=1, branch_offset=32'hFFFF_FFFE → pc=0x0C. Then jump=1, jump_index=26'h40 → pc=0x100.
- At pc=0x100: jr=1, jr_target=0x2000 → pc=0x2000. Then jr_target=0x2002 → pc=0x80, epc=0x2000, misaligned pulses once, instret unchanged.
- stall held 3 cycles at pc=0x24 with jump=1 asserted → pc stays 0x24, instret frozen. Release stall with jump still high → jump taken.
- halt at pc=0x30 → pc=0x34, fetch_valid=0. resume and exception together → pc=0x80, epc=0x34, state RUN.
- Assert rst_n=0 asynchronously mid-cycle while in HALT with epc=0x34 → pc=0, epc=0, instret=0 immediately, without waiting for a clock edge.
